hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Drives the enable/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable.
- Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a timeout watchdog and saturating stall/flush counters.
- Sits beside the datapath; all pipeline registers take their en/flush inputs from this block.

Parameters:
- WIDTH, 32, width of the performance counters.
- TIMEOUT, 16, maximum number of cycles spent in MEM_WAIT before error.
- TMO_W, 5, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_memtoReg  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch/jump taken, resolved in EX.
- mem_req  in  1  MEM-stage instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register update enable.
- pc_sel  out  1  1 = load branch target.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register clears to NOP.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX register clears to bubble.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_bubble  out  1  MEM/WB captures regWrite=0, memWrite=0.
- dmem_valid  out  1  data-memory request strobe.
- err  out  1  sticky memory-timeout error.
- stall_cnt  out  WIDTH  saturating count of stall cycles.
- flush_cnt  out  WIDTH  saturating count of flush events.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. While rst_n=0 the state is RUN; wait_cnt, stall_cnt, flush_cnt and err are 0.
- Control outputs are combinational from state and inputs, no added latency. Their values under reset are the RUN equations with all inputs 0: pc_en=1, if_id_en=1, id_ex_en=1, ex_mem_en=1, all flushes/bubble/pc_sel/dmem_valid=0.
- dmem_valid = mem_req while in RUN or MEM_WAIT; it is 0 in ERROR.
- Priority, highest first: memory wait, branch flush, load-use stall.
- RUN, memory wait (mem_req=1, dmem_ready=0):
  - Go to MEM_WAIT next cycle.
  - This cycle: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, no flush, pc_sel=0.
  - stall_cnt increments.
- RUN, branch (ex_branch_taken=1, no memory wait):
  - pc_en=1, pc_sel=1, if_id_flush=1, id_ex_flush=1, all enables 1.
  - flush_cnt increments.
  - Any simultaneous load-use condition is ignored (wrong-path instruction).
- RUN, load-use (ex_memtoReg=1, ex_rd!=0, and ex_rd==id_rs1 or (id_use_rs2 and ex_rd==id_rs2)):
  - pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
  - Lasts exactly one cycle; stall_cnt increments.
- RUN otherwise: all enables 1, nothing else asserted.
- MEM_WAIT:
  - Pipeline frozen exactly as on RUN entry; wait_cnt increments each cycle.
  - dmem_ready=1: return to RUN; that same cycle the outputs follow the RUN equations with the wait treated as complete (branch or load-use evaluated normally), so the pipeline advances.
  - wait_cnt reaches TIMEOUT-1 without ready: go to ERROR. wait_cnt clears on every exit.
  - ex_branch_taken is ignored while frozen; it is re-evaluated on exit.
- ERROR: all enables 0, mem_wb_bubble=1, err=1. Left only via reset.
- Counters saturate at all-ones and never wrap. stall_cnt counts every cycle with pc_en=0, including ERROR.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters 0.

Decomposition:
- Shared package pipe_pkg: typedef hz_state_e {RUN, MEM_WAIT, ERROR}, constant REG_X0=5'd0, and struct pipe_ctrl_t bundling the en/flush signals.
- One sub-module: sat_counter (parameter WIDTH; inc input, async active-low clear), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_memtoReg=1, ex_rd=5, id_rs1=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for 1 cycle; stall_cnt=1.
- Same hazard with ex_rd=0, or id_rs2=5 with id_use_rs2=0 -> no stall; all enables 1.
- Branch plus load-use in the same cycle -> pc_sel=1, if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles frozen with mem_wb_bubble=1, advance on cycle 4; stall_cnt=3, state RUN.
- dmem_ready never asserted -> err=1 after 16 cycles, enables stay 0; pulse rst_n low -> err=0, counters 0, state RUN.
- Preload stall_cnt to all-ones (force) and stall again -> stays 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Enable/flush controls for the PC and the pipeline registers.
   typedef struct packed {
      logic pc_en;
      logic pc_sel;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic mem_wb_bubble;
   } pipe_ctrl_t;

   // Field order: pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble
   localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc_i, holds at all-ones, async clear.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count up on request, stopping at all-ones so the value never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes,
// data-memory wait freeze with timeout watchdog, and performance counters.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16,
   parameter int TMO_W   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memtoReg,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_en,
   output logic             pc_sel,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_bubble,
   output logic             dmem_valid,
   output logic             err,
   output logic [WIDTH-1:0] stall_cnt,
   output logic [WIDTH-1:0] flush_cnt
);

   hz_state_e        state_q, state_d;
   logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
   pipe_ctrl_t       ctrl;
   logic             load_use;
   logic             wait_pending;

   // A load in EX whose destination feeds the ID instruction; x0 never hazards.
   assign load_use = ex_memtoReg && (ex_rd != REG_X0) &&
                     ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

   // Memory access still outstanding this cycle: in RUN it is a new request
   // not yet ready, in MEM_WAIT it is simply the absence of ready.
   assign wait_pending = (state_q == MEM_WAIT) ? !dmem_ready
                                                : (mem_req && !dmem_ready);

   // Control outputs: priority memory wait, then branch flush, then load-use stall.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      ctrl = CTRL_RUN;
      if (state_q == ERROR) begin
         ctrl = CTRL_FROZEN;
      end else if (wait_pending) begin
         ctrl = CTRL_FROZEN;
      end else if (ex_branch_taken) begin
         ctrl = CTRL_BRANCH;
      end else if (load_use) begin
         ctrl = CTRL_LOAD_USE;
      end
   end

   // Next state and watchdog count; the count clears on every exit from MEM_WAIT.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         RUN: begin
            wait_cnt_d = '0;
            if (mem_req && !dmem_ready) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TMO_W'(TIMEOUT - 1)) begin
               state_d    = ERROR;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + TMO_W'(1);
            end
         end
         ERROR: begin
            wait_cnt_d = '0;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // State register and watchdog counter; ERROR is left only through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign pc_en         = ctrl.pc_en;
   assign pc_sel        = ctrl.pc_sel;
   assign if_id_en      = ctrl.if_id_en;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_en      = ctrl.id_ex_en;
   assign id_ex_flush   = ctrl.id_ex_flush;
   assign ex_mem_en     = ctrl.ex_mem_en;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;
   assign dmem_valid    = mem_req && (state_q != ERROR);
   assign err           = (state_q == ERROR);

   // Every cycle the PC is held counts as a stall; every branch redirect is a flush.
   sat_counter #(.WIDTH(WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (!ctrl.pc_en),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.WIDTH(WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (ctrl.pc_sel),
      .cnt_o (flush_cnt)
   );

endmodule
